// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The WIDTH-bit word is split into BLOCK-bit lookahead groups; group k is resolved in
// pipeline stage k, so the critical path spans a single group rather than the full word.
// Optional feature: define CLA_PIPE_SAT_EN to saturate out_sum to the signed limit on overflow.
module cla_pipe_adder #(
   parameter int WIDTH = 12,
   parameter int BLOCK = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NUM_BLK = WIDTH / BLOCK;
   // Stage k keeps (k+1)*BLOCK finished sum bits; all stages are packed into one vector.
   localparam int SUM_W   = BLOCK * NUM_BLK * (NUM_BLK + 1) / 2;
   // Operand skew entries: entry 0 is the raw input word, entry m (m >= 1) is what stage m-1
   // still has to pass on, WIDTH - m*BLOCK bits wide. Entry m starts at m*WIDTH - BLOCK*m*(m-1)/2.
   localparam int REM_W   = NUM_BLK * WIDTH - BLOCK * NUM_BLK * (NUM_BLK - 1) / 2;

   logic [NUM_BLK-1:0] v;        // stage valid bits
   logic [NUM_BLK-1:0] adv;      // stage k hands its beat onward this cycle
   logic [NUM_BLK-1:0] load;     // stage k captures a new beat this cycle
   logic [NUM_BLK:0]   cvec;     // cvec[0] = effective carry-in, cvec[k+1] = stage k group carry-out
   logic [SUM_W-1:0]   sum_flat;
   logic [REM_W-1:0]   rem_a;
   logic [REM_W-1:0]   rem_b;
   logic [WIDTH-1:0]   b_eff;
   logic               cm_r;     // carry into the word MSB, held by the last stage

   // Full lookahead inside one group: every carry is a flat sum of products of G, P and the carry-in.
   function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] g,
                                                  input logic [BLOCK-1:0] p,
                                                  input logic             ci);
      logic [BLOCK:0] c;
      logic           t;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         t = ci;
         for (int m = 0; m <= i; m++) t = t & p[m];
         c[i+1] = t;
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int m = j + 1; m <= i; m++) t = t & p[m];
            c[i+1] = c[i+1] | t;
         end
      end
      return c;
   endfunction

   // Subtraction is A + ~B + 1; in_cin only matters in add mode.
   assign b_eff             = in_sub ? ~in_b : in_b;
   assign cvec[0]           = in_sub | in_cin;
   assign rem_a[WIDTH-1:0]  = in_a;
   assign rem_b[WIDTH-1:0]  = b_eff;

   // Backpressure chain, resolved from the output back to the input so bubbles collapse.
   always_comb begin
      adv              = '0;
      load             = '0;
      adv[NUM_BLK-1]   = v[NUM_BLK-1] & out_ready;
      for (int k = NUM_BLK - 2; k >= 0; k--) begin
         adv[k] = v[k] & (~v[k+1] | adv[k+1]);
      end
      in_ready = ~v[0] | adv[0];
      load[0]  = in_valid & in_ready;
      for (int k = 1; k < NUM_BLK; k++) begin
         load[k] = adv[k-1];
      end
   end

   for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_stage
      localparam int SW   = (gi + 1) * BLOCK;
      localparam int SOFF = BLOCK * gi * (gi + 1) / 2;
      localparam int ROFF = gi * WIDTH - BLOCK * gi * (gi - 1) / 2;

      logic [BLOCK-1:0] ga, gb, gp, gg, gs;
      logic [BLOCK:0]   gc;
      logic [SW-1:0]    sum_next;
      logic [SW-1:0]    sum_r;
      logic             v_r;
      logic             co_r;

      // The lowest BLOCK bits of this stage's skew entry are the group it resolves now.
      assign ga = rem_a[ROFF +: BLOCK];
      assign gb = rem_b[ROFF +: BLOCK];
      assign gp = ga ^ gb;
      assign gg = ga & gb;
      assign gc = cla_carries(gg, gp, cvec[gi]);
      assign gs = gp ^ gc[BLOCK-1:0];

      if (gi == 0) begin : g_lsb
         assign sum_next = gs;
      end else begin : g_upper
         assign sum_next = {gs, sum_flat[SOFF - gi*BLOCK +: gi*BLOCK]};
      end

      // Stage register: valid plus finished sum bits and group carry; data moves only on transfer.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_r   <= 1'b0;
            sum_r <= '0;
            co_r  <= 1'b0;
         end else if (load[gi]) begin
            v_r   <= 1'b1;
            sum_r <= sum_next;
            co_r  <= gc[BLOCK];
         end else if (adv[gi]) begin
            v_r   <= 1'b0;
         end
      end

      assign v[gi]              = v_r;
      assign sum_flat[SOFF +: SW] = sum_r;
      assign cvec[gi+1]         = co_r;

      if (gi < NUM_BLK - 1) begin : g_skew
         localparam int RW   = WIDTH - SW;
         localparam int NOFF = ROFF + WIDTH - gi * BLOCK;
         logic [RW-1:0] ra_r, rb_r;

         // Carry the not-yet-added operand bits along with the beat.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ra_r <= '0;
               rb_r <= '0;
            end else if (load[gi]) begin
               ra_r <= rem_a[ROFF + BLOCK +: RW];
               rb_r <= rem_b[ROFF + BLOCK +: RW];
            end
         end

         assign rem_a[NOFF +: RW] = ra_r;
         assign rem_b[NOFF +: RW] = rb_r;
      end else begin : g_msb
         // Last stage also keeps the carry into the MSB for the signed overflow flag.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cm_r <= 1'b0;
            end else if (load[gi]) begin
               cm_r <= gc[BLOCK-1];
            end
         end
      end
   end

   assign out_valid = v[NUM_BLK-1];
   assign out_cout  = cvec[NUM_BLK];
   assign out_ovf   = cm_r ^ cvec[NUM_BLK];

`ifdef CLA_PIPE_SAT_EN
   logic [WIDTH-1:0] last_sum;
   assign last_sum = sum_flat[SUM_W-WIDTH +: WIDTH];
   // On overflow the wrapped MSB is the inverse of the common operand sign, so the limit
   // is built from it: sign 0 -> 011..1, sign 1 -> 100..0.
   assign out_sum  = out_ovf ? {~last_sum[WIDTH-1], {(WIDTH-1){last_sum[WIDTH-1]}}} : last_sum;
`else
   assign out_sum  = sum_flat[SUM_W-WIDTH +: WIDTH];
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for cla_pipe_adder (WIDTH=12, BLOCK=3).
// Accepted beats push an arithmetic reference result; a monitor pops and compares each emitted result.
module tb_cla_pipe_adder;
   localparam int WIDTH   = 12;
   localparam int BLOCK   = 3;
   localparam int NUM_BLK = WIDTH / BLOCK;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid, in_ready, in_cin, in_sub;
   logic [WIDTH-1:0] in_a, in_b;
   logic             out_valid, out_ready, out_cout, out_ovf;
   logic [WIDTH-1:0] out_sum;

   int n_checks = 0;
   int n_fail   = 0;
   logic [13:0] exp_q[$];

   int  c_sent, c_emits, c_first, c_last, c_lat;
   bit  c_flag, c_need;

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   // Reference: plain integer arithmetic on the effective operands.
   function automatic logic [13:0] model(input logic [11:0] a, input logic [11:0] b,
                                         input logic cin, input logic sub);
      int bb, ci, full, sa, sb, sr;
      logic [11:0] s;
      logic co, ov;
      bb   = sub ? (4095 - int'(b)) : int'(b);
      ci   = sub ? 1 : int'(cin);
      full = int'(a) + bb + ci;
      s    = full[11:0];
      co   = full[12];
      sa   = (a >= 12'd2048) ? int'(a) - 4096 : int'(a);
      sb   = (bb >= 2048) ? bb - 4096 : bb;
      sr   = sa + sb + ci;
      ov   = (sr > 2047) || (sr < -2048);
`ifdef CLA_PIPE_SAT_EN
      if (ov) s = (sa < 0) ? 12'h800 : 12'h7FF;
`endif
      return {co, ov, s};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard producer: every accepted beat pushes its expected result.
   always @(negedge clk) begin
      if (!rst && in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
   end

   // Monitor: every emitted result is compared against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h with no beat outstanding at %0t",
                     {out_cout, out_ovf, out_sum}, $time);
         end else begin
            check("result", {18'd0, out_cout, out_ovf, out_sum}, {18'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic rand_beat();
      in_a   = 12'($urandom);
      in_b   = 12'($urandom);
      in_cin = 1'($urandom);
      in_sub = 1'($urandom);
   endtask

   // Offer one beat and hold it until accepted; returns 1 ns after the accepting edge.
   task automatic send(input logic [11:0] a, input logic [11:0] b, input logic cin, input logic sub);
      int n;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) check("send_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic directed(input string nm, input logic [11:0] a, input logic [11:0] b,
                           input logic cin, input logic sub,
                           input logic [11:0] e_sum, input logic e_cout, input logic e_ovf);
      int lat;
      send(a, b, cin, sub);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      check({nm, "_latency"}, lat, NUM_BLK - 1);
      check({nm, "_sum"}, {20'd0, out_sum}, {20'd0, e_sum});
      check({nm, "_cout"}, {31'd0, out_cout}, {31'd0, e_cout});
      check({nm, "_ovf"}, {31'd0, out_ovf}, {31'd0, e_ovf});
      @(posedge clk); #1;
   endtask

   initial begin
      in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_sum", {20'd0, out_sum}, 32'd0);
      check("rst_out_cout", {31'd0, out_cout}, 32'd0);
      check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Directed arithmetic corner cases
      directed("add_cin", 12'h123, 12'h456, 1'b1, 1'b0, 12'h57A, 1'b0, 1'b0);
      directed("ripple", 12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      directed("sub_borrow", 12'h005, 12'h007, 1'b1, 1'b1, 12'hFFE, 1'b0, 1'b0);
`ifdef CLA_PIPE_SAT_EN
      directed("ovf_pos", 12'h7FF, 12'h001, 1'b0, 1'b0, 12'h7FF, 1'b0, 1'b1);
      directed("ovf_neg", 12'h800, 12'h001, 1'b0, 1'b1, 12'h800, 1'b1, 1'b1);
`else
      directed("ovf_pos", 12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
      directed("ovf_neg", 12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
`endif

      // Backpressure: 8 beats, out_ready low for cycles 3..7
      c_sent = 0; c_emits = 0; c_first = -1; c_last = -1; c_flag = 1'b0; c_need = 1'b1;
      for (int c = 0; c < 40; c++) begin
         out_ready = !(c >= 3 && c <= 7);
         in_valid  = (c_sent < 8);
         if (c_need) begin rand_beat(); c_need = 1'b0; end
         @(negedge clk);
         if (c == 3) check("bp_ready_c3", {31'd0, in_ready}, 32'd1);
         if (c == 4) check("bp_ready_c4", {31'd0, in_ready}, 32'd0);
         if (!in_ready) c_flag = 1'b1;
         if (in_valid && in_ready) begin c_sent++; c_need = 1'b1; end
         if (out_valid && out_ready) begin
            c_emits++;
            if (c_first < 0) c_first = c;
            c_last = c;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_stalled", {31'd0, c_flag}, 32'd1);
      check("bp_sent", c_sent, 32'd8);
      check("bp_emits", c_emits, 32'd8);
      check("bp_first_emit", c_first, 32'd8);
      check("bp_no_gaps", c_last - c_first, 32'd7);

      // Bubble collapse: beats at cycles 0 and 3 with out_ready low until cycle 10
      c_emits = 0; c_first = -1; c_last = -1; c_flag = 1'b0;
      for (int c = 0; c < 20; c++) begin
         out_ready = (c >= 10);
         in_valid  = (c == 0 || c == 3);
         if (in_valid) rand_beat();
         @(negedge clk);
         if (!in_ready) c_flag = 1'b1;
         if (c == 9) check("bubble_out_valid", {31'd0, out_valid}, 32'd1);
         if (out_valid && out_ready) begin
            c_emits++;
            if (c_first < 0) c_first = c;
            c_last = c;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bubble_ready_low", {31'd0, c_flag}, 32'd0);
      check("bubble_emits", c_emits, 32'd2);
      check("bubble_first", c_first, 32'd10);
      check("bubble_last", c_last, 32'd11);

      // Reset mid-flight
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         rand_beat();
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_out_sum", {20'd0, out_sum}, 32'd0);
      check("mrst_out_cout", {31'd0, out_cout}, 32'd0);
      check("mrst_out_ovf", {31'd0, out_ovf}, 32'd0);
      check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      c_emits = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) c_emits++;
      end
      check("mrst_no_stale", c_emits, 32'd0);
      @(posedge clk); #1;
      directed("post_rst", 12'h0F0, 12'h00F, 1'b0, 1'b0, 12'h0FF, 1'b0, 1'b0);

      // Random traffic with random backpressure
      c_need = 1'b1;
      for (int c = 0; c < 300; c++) begin
         out_ready = ($urandom_range(2, 0) != 0);
         if (c_need) begin
            in_valid = ($urandom_range(3, 0) != 0);
            rand_beat();
         end
         @(negedge clk);
         c_need = !in_valid || in_ready;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
      @(negedge clk);
      check("drain_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the Binary-MLP datapath. The WIDTH-bit operation is split into BLOCK-bit lookahead groups, with one register stage per group. This gives one result per cycle at a clock rate set by a single group rather than the full word. It sits between the popcount/XNOR stage and the neuron accumulator/threshold logic, and carries a valid/ready handshake with full backpressure.

## Interface
- WIDTH, 12, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 3, lookahead group width in bits, 1..8; NUM_BLK = WIDTH/BLOCK pipeline stages.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage 0 can accept; a beat transfers when in_valid && in_ready.
- in_a  input  WIDTH  operand A (two's complement for overflow purposes).
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in; used in add mode only.
- in_sub  input  1  0 = A + B + cin; 1 = A - B (B inverted, carry-in forced to 1, in_cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts; a result transfers when out_valid && out_ready.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of the MSB; in sub mode, 1 = no borrow.
- out_ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- Group k (k = 0..NUM_BLK-1) covers bits [k*BLOCK +: BLOCK].
- Per bit: P = a ^ b', G = a & b', where b' = sub ? ~b : b.
- Group carries use full lookahead within the group: c[i+1] = G[i] | P[i]&c[i], expanded as a flat sum-of-products. Sum bit s[i] = P[i] ^ c[i].
- Stage k register holds:
  - valid bit;
  - completed sum bits [0 .. (k+1)*BLOCK-1];
  - group carry-out;
  - carry into the group's MSB (needed only for the last group);
  - remaining unprocessed a / b' bits (operand skew).
- Stage k computes group k from stage k-1's carry, or from cin_eff for k = 0. cin_eff = sub ? 1 : in_cin.
- The last stage drives out_sum/out_cout/out_ovf directly from its registers (no combinational path from inputs to outputs).
- Flow control, per stage:
  - adv[k] = v[k] && (!v[k+1] || adv[k+1]).
  - For the last stage, adv = out_valid && out_ready.
  - in_ready = !v[0] || adv[0]. Bubbles collapse; a stalled output does not block upstream stages that have empty slots ahead of them.
- A stage whose valid is 0 holds its data registers (no toggling). Data is captured only on transfer into the stage.
- Order is strictly preserved; no beat is dropped or duplicated.
- Width rules:
  - Result is WIDTH bits, modulo 2^WIDTH.
  - out_cout is the true (WIDTH+1)-th bit.
  - out_ovf is computed on the effective operands (A, B') regardless of mode.

## Timing
- Reset (async assert, sync release):
  - all stage valids = 0;
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0;
  - in_ready = 1 from the first cycle after reset release.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+NUM_BLK-1, i.e. NUM_BLK cycles of pipeline. Default WIDTH = 12 with BLOCK = 3 gives 4.
- Throughput: 1 beat/cycle while out_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0 within the same cycle (combinational from out_ready through the adv chain).
- Simultaneous accept and emit in the same cycle is legal and required at full throughput.
- Reset mid-operation discards all in-flight beats; nothing is emitted for them after release.
- in_sub, in_cin, in_a and in_b are sampled only on the accepting edge; later changes do not affect in-flight beats.

## Configuration
- CLA_PIPE_SAT_EN defined:
  - when overflow occurs, out_sum saturates to the signed limit;
  - saturation value is 0111…1 if the effective operand sign bits are 0, and 1000…0 if they are 1;
  - the decision is made in the last stage, with no added latency;
  - out_ovf still reports the overflow; out_cout is unchanged (raw).
- CLA_PIPE_SAT_EN undefined:
  - out_sum always wraps modulo 2^WIDTH;
  - no saturation logic is generated.

## Test plan
- Add, cin = 1: 0x123 + 0x456 + 1 -> out_sum 0x57A, cout 0, ovf 0, out_valid exactly 4 cycles after accept (WIDTH = 12, BLOCK = 3).
- Full-width carry ripple: 0xFFF + 0x001, cin 0 -> 0x000, cout 1, ovf 0. Repeat with sub = 1: 0x005 - 0x007 -> 0xFFE, cout 0 (borrow), ovf 0, and in_cin = 1 ignored.
- Signed overflow: 0x7FF + 0x001 -> ovf 1, out_sum 0x800 without macro / 0x7FF with CLA_PIPE_SAT_EN. Also 0x800 - 0x001 -> ovf 1, 0x7FF without macro / 0x800 with.
- Backpressure: stream 8 random beats with in_valid = 1 and out_ready = 0 for cycles 3–7:
  - in_ready drops once 4 beats are held;
  - after out_ready returns, all 8 results emerge in order, bit-exact against a reference model, with no gaps at out_ready = 1.
- Bubble collapse: accept beats at cycles 0 and 3 with out_ready = 0 -> both occupy the last two stages and in_ready stays 1. Release -> results on consecutive cycles.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle on the next edge -> out_valid, out_sum, out_cout and out_ovf all 0; no stale result emitted; in_ready = 1; a new beat completes with 4-cycle latency.
